// File: rtl/product_accumulator_4bits_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared product width and accumulator FSM state encoding used
//               by the multiplier family and its accumulator stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    localparam int PRODUCT_WIDTH = 8;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/product_accumulator_4bits_if.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator_4bits_if
// Description : Product input stream and result output stream of the
//               accumulator, each with its own valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface product_accumulator_4bits_if
    import mult_pkg::*;
#(
    parameter int ACC_WIDTH   = 16,
    parameter int COUNT_WIDTH = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [PRODUCT_WIDTH-1:0] in_product;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_WIDTH-1:0]     out_sum;
    logic [COUNT_WIDTH-1:0]   out_count;
    logic                     out_overflow;

    // Environment side: produces beats, consumes results
    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow
    );

    // Accumulator side
    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow
    );
endinterface : product_accumulator_4bits_if
`default_nettype wire

// File: rtl/product_accumulator_4bits_sat_add_ovf.sv
`default_nettype none
// ============================================================================
// Module      : sat_add_ovf
// Description : W-bit accumulator plus zero-extended BW-bit addend. Reports
//               carry-out as overflow; result clamps to all-ones or wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_add_ovf #(
    parameter int W        = 16,
    parameter int BW       = 8,
    parameter int SATURATE = 1
) (
    input  wire logic [W-1:0]  a,
    input  wire logic [BW-1:0] b,
    output logic      [W-1:0]  sum,
    output logic               ovf
);
    logic [W:0] w_full;

    // One extra bit so the carry-out is visible as the overflow indication
    assign w_full = {1'b0, a} + {{(W + 1 - BW){1'b0}}, b};
    assign ovf    = w_full[W];

    generate
        if (SATURATE != 0) begin : g_sat
            assign sum = w_full[W] ? {W{1'b1}} : w_full[W-1:0];
        end else begin : g_wrap
            assign sum = w_full[W-1:0];
        end
    endgenerate
endmodule : sat_add_ovf
`default_nettype wire

// File: rtl/product_accumulator_4bits.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator_4bits
// Description : Sums bursts of 8-bit products (closed by in_last) into an
//               ACC_WIDTH total with beat count and sticky overflow; result
//               is held in a registered valid/ready output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator_4bits
    import mult_pkg::*;
#(
    parameter int ACC_WIDTH   = 16,
    parameter int COUNT_WIDTH = 8,
    parameter int SATURATE    = 1
) (
    input wire logic                clk,
    input wire logic                rst_n,
    product_accumulator_4bits_if.slave bus
);
    acc_state_t             r_state;
    acc_state_t             w_state_nxt;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [COUNT_WIDTH-1:0] r_cnt;
    logic                   r_ovf;
    logic                   r_out_valid;
    logic [ACC_WIDTH-1:0]   r_out_sum;
    logic [COUNT_WIDTH-1:0] r_out_count;
    logic                   r_out_overflow;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_publish;
    logic [ACC_WIDTH-1:0]   w_sum_nxt;
    logic                   w_add_ovf;
    logic                   w_ovf_nxt;
    logic [COUNT_WIDTH-1:0] w_cnt_nxt;

    // A pending result that is not being consumed stalls the input entirely
    assign w_in_ready = ~r_out_valid | bus.out_ready;
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_publish  = w_accept & bus.in_last;

    sat_add_ovf #(
        .W        (ACC_WIDTH),
        .BW       (PRODUCT_WIDTH),
        .SATURATE (SATURATE)
    ) u_add (
        .a   (r_acc),
        .b   (bus.in_product),
        .sum (w_sum_nxt),
        .ovf (w_add_ovf)
    );

    assign w_ovf_nxt = r_ovf | w_add_ovf;
    assign w_cnt_nxt = (r_cnt == {COUNT_WIDTH{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACC_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: any accepted last beat closes the burst, other beats open/continue it
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = bus.in_last ? ACC_IDLE : ACC_RUN;
        end
    end

    // Running sum, beat count and sticky overflow; cleared as the burst publishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_publish) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    // Output stage: publish overrides consume so back-to-back results have no bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_sum      <= '0;
            r_out_count    <= '0;
            r_out_overflow <= 1'b0;
        end else if (w_publish) begin
            r_out_valid    <= 1'b1;
            r_out_sum      <= w_sum_nxt;
            r_out_count    <= w_cnt_nxt;
            r_out_overflow <= w_ovf_nxt;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid    <= 1'b0;
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_sum      = r_out_sum;
    assign bus.out_count    = r_out_count;
    assign bus.out_overflow = r_out_overflow;
endmodule : product_accumulator_4bits
`default_nettype wire
